// File: rtl/jk_flip_flop_pkg.sv
// Shared JK encoding for the JK flip-flop bank.
// The {J,K} pair is decoded as an enum so each cell reads as a small case table.
package jk_flip_flop_pkg;

  typedef enum logic [1:0] {
    JK_HOLD   = 2'b00,
    JK_RESET  = 2'b01,
    JK_SET    = 2'b10,
    JK_TOGGLE = 2'b11
  } jk_op_e;

  function automatic logic jk_next(input jk_op_e op, input logic q);
    logic n;
    n = q;
    case (op)
      JK_HOLD:   n = q;
      JK_RESET:  n = 1'b0;
      JK_SET:    n = 1'b1;
      JK_TOGGLE: n = ~q;
      default:   n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Single-bit JK register with synchronous reset, clear and preset.
// Priority: rst > clr > pre > JK rule.
module jk_ff_cell
  import jk_flip_flop_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic pre,
  input  logic j,
  input  logic k,
  output logic q
);

  jk_op_e op;
  logic   jkNext;

  always_comb begin
    op     = jk_op_e'({j, k});
    jkNext = jk_next(op, q);
  end

  // The JK decode is consulted only in the final branch, so unknown J/K cannot
  // leak into q while any of the higher-priority controls is active.
  always_ff @(posedge clk) begin
    if (rst)
      q <= RESET_VAL;
    else if (clr)
      q <= 1'b0;
    else if (pre)
      q <= 1'b1;
    else
      q <= jkNext;
  end

endmodule

// File: rtl/jk_flip_flop.sv
// Bank of WIDTH independent JK flip-flops sharing clock, reset, clear and preset.
// Q_n is derived from the registered Q, so there is no input-to-output path.
module jk_flip_flop
  import jk_flip_flop_pkg::*;
#(
  parameter int                 WIDTH     = 1,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_n,
  input  logic             preset_n,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_n
);

  logic clr;
  logic pre;

  assign clr = ~clear_n;
  assign pre = ~preset_n;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_ff_cell #(
      .RESET_VAL(RESET_VAL[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .pre(pre),
      .j  (J[i]),
      .k  (K[i]),
      .q  (Q[i])
    );
  end

  assign Q_n = ~Q;

endmodule

// File: tb/tb_jk_flip_flop.sv
// Directed, table-driven bench for a 4-bit jk_flip_flop bank with default reset value.
// Inputs change on the falling edge; outputs are checked 1 ns after the rising edge.
module tb_jk_flip_flop;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         clear_n;
  logic         preset_n;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic [W-1:0] Q;
  logic [W-1:0] Q_n;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string        name;
    logic         rst;
    logic         clear_n;
    logic         preset_n;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] expQ;
  } vec_t;

  vec_t vecs[$];

  jk_flip_flop #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .clear_n (clear_n),
    .preset_n(preset_n),
    .J       (J),
    .K       (K),
    .Q       (Q),
    .Q_n     (Q_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic addVec(input string name, input logic r, input logic cn, input logic pn,
                        input logic [W-1:0] j, input logic [W-1:0] k, input logic [W-1:0] e);
    vec_t v;
    v.name = name; v.rst = r; v.clear_n = cn; v.preset_n = pn;
    v.j = j; v.k = k; v.expQ = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic cn, input logic pn,
                               input logic [W-1:0] j, input logic [W-1:0] k);
    @(negedge clk);
    rst = r; clear_n = cn; preset_n = pn; J = j; K = k;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] expQ);
    checks++;
    if (Q !== expQ) begin
      failures++;
      $display("[TB] FAIL %s Q: actual=%b required=%b", name, Q, expQ);
    end
    checks++;
    if (Q_n !== ~expQ) begin
      failures++;
      $display("[TB] FAIL %s Q_n: actual=%b required=%b", name, Q_n, ~expQ);
    end
  endtask

  initial begin
    rst = 1'b0; clear_n = 1'b1; preset_n = 1'b1; J = '0; K = '0;

    //      name            rst cn  pn  J        K        expQ
    addVec("reset",         1, 1, 1, 4'b0000, 4'b0000, 4'b0000);
    addVec("hold0_a",       0, 1, 1, 4'b0000, 4'b0000, 4'b0000);
    addVec("hold0_b",       0, 1, 1, 4'b0000, 4'b0000, 4'b0000);
    addVec("hold0_c",       0, 1, 1, 4'b0000, 4'b0000, 4'b0000);
    addVec("preset_a",      0, 1, 0, 4'b0000, 4'b0000, 4'b1111);
    addVec("clear",         0, 0, 1, 4'b0000, 4'b0000, 4'b0000);
    addVec("preset_b",      0, 1, 0, 4'b0000, 4'b0000, 4'b1111);
    addVec("hold1",         0, 1, 1, 4'b0000, 4'b0000, 4'b1111);
    addVec("jk_reset",      0, 1, 1, 4'b0000, 4'b1111, 4'b0000);
    addVec("jk_set",        0, 1, 1, 4'b1111, 4'b0000, 4'b1111);
    addVec("hold1_a",       0, 1, 1, 4'b0000, 4'b0000, 4'b1111);
    addVec("hold1_b",       0, 1, 1, 4'b0000, 4'b0000, 4'b1111);
    addVec("clear_pre_tgl", 0, 0, 1, 4'b1111, 4'b1111, 4'b0000);
    addVec("toggle1",       0, 1, 1, 4'b1111, 4'b1111, 4'b1111);
    addVec("toggle2",       0, 1, 1, 4'b1111, 4'b1111, 4'b0000);
    addVec("toggle3",       0, 1, 1, 4'b1111, 4'b1111, 4'b1111);
    addVec("toggle4",       0, 1, 1, 4'b1111, 4'b1111, 4'b0000);
    addVec("toggle5",       0, 1, 1, 4'b1111, 4'b1111, 4'b1111);
    addVec("toggle6",       0, 1, 1, 4'b1111, 4'b1111, 4'b0000);
    addVec("preset_c",      0, 1, 0, 4'b0000, 4'b0000, 4'b1111);
    addVec("clear_and_pre", 0, 0, 0, 4'b1111, 4'b0000, 4'b0000);
    addVec("preset_d",      0, 1, 0, 4'b0000, 4'b0000, 4'b1111);
    addVec("rst_over_pre",  1, 1, 0, 4'b1111, 4'b0000, 4'b0000);
    addVec("preset_e",      0, 1, 0, 4'b0000, 4'b0000, 4'b1111);
    addVec("rst_over_clr",  1, 0, 0, 4'b1111, 4'b1111, 4'b0000);
    addVec("load_0011",     0, 1, 1, 4'b0011, 4'b1100, 4'b0011);
    addVec("mixed_bits",    0, 1, 1, 4'b1010, 4'b0110, 4'b1001);
    addVec("tgl_from_1001", 0, 1, 1, 4'b1111, 4'b1111, 4'b0110);
    addVec("rst_mid_tgl",   1, 1, 1, 4'b1111, 4'b1111, 4'b0000);
    addVec("tgl_after_rst", 0, 1, 1, 4'b1111, 4'b1111, 4'b1111);
    addVec("tgl_after_rst2",0, 1, 1, 4'b1111, 4'b1111, 4'b0000);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].clear_n, vecs[i].preset_n, vecs[i].j, vecs[i].k);
      checkOutput(vecs[i].name, vecs[i].expQ);
    end

    // Clear pulse that starts and ends between rising edges must be ignored.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
    checkOutput("pulse_setup", 4'b1111);
    @(negedge clk);
    preset_n = 1'b1;
    #2 clear_n = 1'b0;
    #2 clear_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("clear_between_edges", 4'b1111);

    // Unknown J/K must be masked while a higher-priority control is active.
    applyStimulus(1'b0, 1'b0, 1'b1, 4'bxxxx, 4'bxxxx);
    checkOutput("clear_with_x", 4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'bxxxx, 4'bxxxx);
    checkOutput("preset_with_x", 4'b1111);
    applyStimulus(1'b1, 1'b1, 1'b1, 4'bxxxx, 4'bxxxx);
    checkOutput("rst_with_x", 4'b0000);

    // Independent per-bit behaviour: each bit uses a different JK code.
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b0101, 4'b0000);
    checkOutput("set_0101", 4'b0101);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'b1100, 4'b0110);
    checkOutput("per_bit_ops", 4'b1001);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
